// File: rtl/memshare_pkg.sv
// Shared configuration for the memShare shift sequencer: widths, page layout and FSM states.
package memshare_pkg;

  localparam int RQST_BITWIDTH  = 5;
  localparam int PAGE_NUM       = 1 << RQST_BITWIDTH;
  localparam int SHIFT_BITWIDTH = $clog2(RQST_BITWIDTH);
  localparam int SEQ_SIZE       = 4;
  localparam int PAGE_WIDTH     = SHIFT_BITWIDTH + RQST_BITWIDTH + 1;
  localparam int CNT_BITWIDTH   = $clog2(SEQ_SIZE + 1);

  localparam int SHIFT_LSB = 0;
  localparam int PTR_LSB   = SHIFT_LSB + SHIFT_BITWIDTH;
  localparam int LAST_BIT  = PTR_LSB + RQST_BITWIDTH;

  // Field order matches the offsets above: {last, next_ptr, shift}.
  typedef struct packed {
    logic                      last;
    logic [RQST_BITWIDTH-1:0]  next_ptr;
    logic [SHIFT_BITWIDTH-1:0] shift;
  } page_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_DONE,
    ST_ERR
  } seq_state_e;

endpackage

// File: rtl/memshare_page_file.sv
// Page array: one synchronous write port, one synchronous read port (1-cycle latency, read-first).
module memshare_page_file
  import memshare_pkg::*;
#(
  parameter int ADDR_W = RQST_BITWIDTH,
  parameter int DATA_W = PAGE_WIDTH
) (
  input  logic              sys_clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // NOTE: the array is deliberately left without reset so it maps onto distributed RAM;
  // software must program every page it intends to use.
  always_ff @(posedge sys_clk) begin
    if (we) mem[waddr] <= wdata;
    // NOTE: non-blocking assignments make a same-address read return the pre-write word.
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/memshare_shift_sequencer.sv
// Walks a linked chain of L1PA shift patterns per request and issues them over valid/ready.
module memshare_shift_sequencer
  import memshare_pkg::*;
(
  input  logic                      sys_clk,
  input  logic                      rst,
  input  logic [RQST_BITWIDTH-1:0]  rqst_flag_i,
  input  logic                      rqst_valid_i,
  output logic                      rqst_ready_o,
  output logic [SHIFT_BITWIDTH-1:0] shift_o,
  output logic                      shift_valid_o,
  input  logic                      shift_ready_i,
  output logic                      isGtr_o,
  output logic                      seq_done_o,
  output logic                      seq_err_o,
  input  logic [RQST_BITWIDTH-1:0]  page_waddr_i,
  input  logic [PAGE_WIDTH-1:0]     page_wdata_i,
  input  logic                      page_we_i
);

  seq_state_e                state, next_state;
  logic [CNT_BITWIDTH-1:0]   count;
  logic [RQST_BITWIDTH-1:0]  next_ptr;
  logic                      rd_en;
  logic [RQST_BITWIDTH-1:0]  rd_addr;
  logic [PAGE_WIDTH-1:0]     rd_data;
  page_t                     rd_page;
  logic                      rqst_hs;

  assign rd_page      = page_t'(rd_data);
  assign rqst_ready_o = (state == ST_IDLE);
  assign seq_done_o   = (state == ST_DONE);
  assign seq_err_o    = (state == ST_ERR);
  assign rqst_hs      = rqst_valid_i && rqst_ready_o;

  memshare_page_file u_page_file (
    .sys_clk (sys_clk),
    .we      (page_we_i),
    .waddr   (page_waddr_i),
    .wdata   (page_wdata_i),
    .re      (rd_en),
    .raddr   (rd_addr),
    .rdata   (rd_data)
  );

  // NOTE: every signal gets a default before the case so no path leaves a latch behind.
  always_comb begin
    next_state = state;
    rd_en      = 1'b0;
    rd_addr    = rqst_flag_i;
    case (state)
      ST_IDLE: begin
        if (rqst_hs) begin
          if (rqst_flag_i == '0) begin
            next_state = ST_DONE;
          end else begin
            rd_en      = 1'b1;
            next_state = ST_FETCH;
          end
        end
      end
      ST_FETCH: next_state = ST_ISSUE;
      ST_ISSUE: begin
        if (shift_ready_i) begin
          if (isGtr_o) begin
            next_state = ST_DONE;
          end else if (count == CNT_BITWIDTH'(SEQ_SIZE)) begin
            next_state = ST_ERR;
          end else begin
            rd_en      = 1'b1;
            rd_addr    = next_ptr;
            next_state = ST_FETCH;
          end
        end
      end
      ST_DONE: next_state = ST_IDLE;
      ST_ERR:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      count         <= '0;
      next_ptr      <= '0;
      shift_o       <= '0;
      isGtr_o       <= 1'b0;
      shift_valid_o <= 1'b0;
    end else begin
      state <= next_state;

      if (state == ST_IDLE && rqst_hs) begin
        count <= CNT_BITWIDTH'(1);
      end else if (state == ST_ISSUE && next_state == ST_FETCH) begin
        count <= count + CNT_BITWIDTH'(1);
      end

      // Output registers load from the page word one cycle after its read was issued.
      if (state == ST_FETCH) begin
        shift_o       <= rd_page.shift;
        isGtr_o       <= rd_page.last;
        next_ptr      <= rd_page.next_ptr;
        shift_valid_o <= 1'b1;
      end else if (state == ST_ISSUE && shift_ready_i) begin
        shift_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memshare_shift_sequencer.sv
// Self-checking bench: directed scenarios plus random page chains against a linked-list walk model.
module tb_memshare_shift_sequencer;
  import memshare_pkg::*;

  logic                      sys_clk = 1'b0;
  logic                      rst = 1'b1;
  logic [RQST_BITWIDTH-1:0]  rqst_flag_i = '0;
  logic                      rqst_valid_i = 1'b0;
  logic                      rqst_ready_o;
  logic [SHIFT_BITWIDTH-1:0] shift_o;
  logic                      shift_valid_o;
  logic                      shift_ready_i = 1'b0;
  logic                      isGtr_o;
  logic                      seq_done_o;
  logic                      seq_err_o;
  logic [RQST_BITWIDTH-1:0]  page_waddr_i = '0;
  logic [PAGE_WIDTH-1:0]     page_wdata_i = '0;
  logic                      page_we_i = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Expected page contents, updated whenever the bench writes the DUT page file.
  logic [8:0] model_mem [32];

  memshare_shift_sequencer dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .rqst_flag_i   (rqst_flag_i),
    .rqst_valid_i  (rqst_valid_i),
    .rqst_ready_o  (rqst_ready_o),
    .shift_o       (shift_o),
    .shift_valid_o (shift_valid_o),
    .shift_ready_i (shift_ready_i),
    .isGtr_o       (isGtr_o),
    .seq_done_o    (seq_done_o),
    .seq_err_o     (seq_err_o),
    .page_waddr_i  (page_waddr_i),
    .page_wdata_i  (page_wdata_i),
    .page_we_i     (page_we_i)
  );

  initial forever #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [8:0] pg(input bit last, input int ptr, input int sh);
    return {last, 5'(ptr), 3'(sh)};
  endfunction

  task automatic write_page(input int addr, input logic [8:0] data);
    page_waddr_i = 5'(addr);
    page_wdata_i = data;
    page_we_i    = 1'b1;
    tick();
    page_we_i      = 1'b0;
    model_mem[addr] = data;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".ready"}, rqst_ready_o, 1);
    check({tag, ".valid"}, shift_valid_o, 0);
    check({tag, ".shift"}, shift_o, 0);
    check({tag, ".isgtr"}, isGtr_o, 0);
    check({tag, ".done"}, seq_done_o, 0);
    check({tag, ".err"}, seq_err_o, 0);
  endtask

  // Sends one request and follows the whole sequence cycle by cycle. The expected pattern
  // list is obtained by walking model_mem from the flag, reading each page when its fetch
  // is issued, until a last page or SEQ_SIZE shifts. Optionally writes one page during
  // the first pattern's wait.
  task automatic run_seq(input string tag, input int flag, input int stall_lo, input int stall_hi,
                         input bit mid_we, input int mid_addr, input logic [8:0] mid_data);
    logic [8:0] cur;
    int         shifts;
    int         stall;
    bit         pending;
    bit         finished;
    pending = mid_we;
    check({tag, ".idle_ready"}, rqst_ready_o, 1);
    rqst_flag_i  = 5'(flag);
    rqst_valid_i = 1'b1;
    tick();
    rqst_valid_i = 1'b0;
    if (flag == 0) begin
      check({tag, ".bypass_done"}, seq_done_o, 1);
      check({tag, ".bypass_valid"}, shift_valid_o, 0);
      check({tag, ".bypass_ready"}, rqst_ready_o, 0);
      tick();
      check({tag, ".bypass_ready_back"}, rqst_ready_o, 1);
      check({tag, ".bypass_done_off"}, seq_done_o, 0);
      return;
    end
    cur      = model_mem[flag];
    shifts   = 0;
    finished = 1'b0;
    while (!finished) begin
      check({tag, ".fetch_valid"}, shift_valid_o, 0);
      check({tag, ".fetch_ready"}, rqst_ready_o, 0);
      check({tag, ".fetch_pulse"}, {seq_done_o, seq_err_o}, 0);
      tick();
      shifts++;
      stall = $urandom_range(stall_hi, stall_lo);
      if (pending && stall == 0) stall = 1;
      for (int i = 0; i < stall; i++) begin
        check({tag, ".hold_valid"}, shift_valid_o, 1);
        check({tag, ".hold_shift"}, shift_o, cur[2:0]);
        check({tag, ".hold_isgtr"}, isGtr_o, cur[8]);
        check({tag, ".hold_ready"}, rqst_ready_o, 0);
        if (pending) begin
          page_waddr_i = 5'(mid_addr);
          page_wdata_i = mid_data;
          page_we_i    = 1'b1;
        end
        tick();
        if (pending) begin
          page_we_i           = 1'b0;
          model_mem[mid_addr] = mid_data;
          pending             = 1'b0;
        end
      end
      check({tag, ".hs_valid"}, shift_valid_o, 1);
      check({tag, ".hs_shift"}, shift_o, cur[2:0]);
      check({tag, ".hs_isgtr"}, isGtr_o, cur[8]);
      check({tag, ".hs_pulse"}, {seq_done_o, seq_err_o}, 0);
      shift_ready_i = 1'b1;
      if (cur[8]) begin
        tick();
        shift_ready_i = 1'b0;
        check({tag, ".end_valid"}, shift_valid_o, 0);
        check({tag, ".done_pulse"}, {seq_done_o, seq_err_o}, 2'b10);
        finished = 1'b1;
      end else if (shifts == SEQ_SIZE) begin
        tick();
        shift_ready_i = 1'b0;
        check({tag, ".end_valid"}, shift_valid_o, 0);
        check({tag, ".err_pulse"}, {seq_done_o, seq_err_o}, 2'b01);
        finished = 1'b1;
      end else begin
        cur = model_mem[cur[7:3]];
        tick();
        shift_ready_i = 1'b0;
      end
    end
    tick();
    check({tag, ".ready_back"}, rqst_ready_o, 1);
    check({tag, ".pulse_off"}, {seq_done_o, seq_err_o}, 0);
  endtask

  initial begin
    tick();
    check_reset_outputs("reset_hold");
    tick();
    rst = 1'b0;
    tick();
    check_reset_outputs("after_reset");

    // Single-pattern sequence.
    write_page(5, pg(1, 0, 3));
    run_seq("s1", 5, 0, 0, 1'b0, 0, '0);

    // Three-pattern chain, immediate then heavily stalled consumer.
    write_page(6, pg(0, 9, 1));
    write_page(9, pg(0, 12, 2));
    write_page(12, pg(1, 0, 4));
    run_seq("s2", 6, 0, 0, 1'b0, 0, '0);
    run_seq("s3", 6, 5, 5, 1'b0, 0, '0);

    // Self-loop ends through the watchdog.
    write_page(7, pg(0, 7, 2));
    run_seq("s4", 7, 0, 1, 1'b0, 0, '0);

    // Zero flag bypass.
    run_seq("s5", 0, 0, 0, 1'b0, 0, '0);

    // Reprogram the second link while the first pattern waits.
    run_seq("s6", 6, 1, 2, 1'b1, 9, pg(1, 0, 7));

    // Reset while a pattern is being offered.
    rqst_flag_i  = 5'd6;
    rqst_valid_i = 1'b1;
    tick();
    rqst_valid_i = 1'b0;
    tick();
    tick();
    check("rst_mid.valid_before", shift_valid_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("rst_mid");
    tick();
    check_reset_outputs("rst_mid_next");

    // Random page chains with random backpressure.
    for (int a = 0; a < 32; a++) begin
      write_page(a, {($urandom_range(2, 0) == 0), 5'($urandom), 3'($urandom)});
    end
    for (int n = 0; n < 40; n++) begin
      run_seq($sformatf("rnd%0d", n), int'($urandom_range(31, 0)), 0, 3, 1'b0, 0, '0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
